io_port_bank: RTL and testbench



---
 rtl/io_port_bank_pkg.sv | 16 +
 rtl/io_port_bank_fifo.sv | 68 ++++++
 rtl/io_port_bank.sv | 159 +++++++++++++++
 tb/tb_io_port_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_bank_pkg.sv
// Shared constants for the processor I/O port bank: read addresses and
// the bit layout of the FIFO status word.
package io_port_bank_pkg;

  // Read-side address map
  localparam int unsigned IOA_FIFO  = 32'd0;
  localparam int unsigned IOA_STAT  = 32'd1;
  localparam int unsigned IOA_GPIO0 = 32'd2;

  // Status word bit positions
  localparam int unsigned ST_EMPTY = 32'd0;
  localparam int unsigned ST_FULL  = 32'd1;
  localparam int unsigned ST_UNDF  = 32'd2;
  localparam int unsigned ST_CNT   = 32'd3;

endpackage

// File: rtl/io_port_bank_fifo.sv
// Synchronous FIFO with a combinational head output. Pushes are ignored
// while full and pops are ignored while empty, so the caller may issue
// raw requests. Pointers wrap naturally because DEPTH is a power of two.
module io_fifo #(
  parameter int NBDATA = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [NBDATA-1:0]          din,
  output logic [NBDATA-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [NBDATA-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              push_s;
  logic              pop_s;

  assign empty  = (count_r == CW'(0));
  assign full   = (count_r == CW'(DEPTH));
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Storage array: cleared on reset so stale data never reaches the head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Peripheral-side responder for the processor I/O bus: output port
// registers with write strobes, a buffered input stream drained through
// address 0, a status word at address 1, sampled GPIO words above that,
// and a level interrupt on FIFO fill.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int NBIOIN = 2,
  parameter int NBIOOU = 2,
  parameter int FDEPTH = 8,
  parameter int ITRTHR = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUBITS-1:0]                    io_out,
  input  logic [NBIOOU-1:0]                    addr_out,
  input  logic                                 out_en,
  input  logic [NBIOIN-1:0]                    addr_in,
  input  logic                                 req_in,
  output logic [NUBITS-1:0]                    io_in,
  output logic                                 itr,
  input  logic [NUBITS-1:0]                    ext_data,
  input  logic                                 ext_valid,
  output logic                                 ext_ready,
  input  logic [((2**NBIOIN)-2)*NUBITS-1:0]    ext_gpio,
  output logic [(2**NBIOOU)*NUBITS-1:0]        port_q,
  output logic [(2**NBIOOU)-1:0]               port_stb
);

  localparam int CW    = $clog2(FDEPTH+1);
  localparam int NGPIO = (2**NBIOIN) - 2;

  if (NUBITS < 3 + CW) begin : g_chk_width
    $error("io_port_bank: NUBITS too narrow for the status word");
  end
  if (NBIOIN < 2) begin : g_chk_nbioin
    $error("io_port_bank: NBIOIN must be at least 2");
  end
  if ((ITRTHR < 1) || (ITRTHR > FDEPTH)) begin : g_chk_thr
    $error("io_port_bank: ITRTHR out of range 1..FDEPTH");
  end

  logic [NUBITS-1:0]       fifo_dout_s;
  logic [CW-1:0]           fifo_count_s;
  logic                    fifo_empty_s;
  logic                    fifo_full_s;
  logic                    push_s;
  logic                    pop_req_s;
  logic                    pop_s;
  logic                    stat_req_s;
  logic [CW-1:0]           count_next_s;
  logic                    underflow_r;
  logic [NGPIO*NUBITS-1:0] gpio_r;
  logic [NBIOIN-1:0]       gpio_sel_s;
  logic [NUBITS-1:0]       status_s;
  logic [NUBITS-1:0]       rd_data_s;

  // Acceptance is judged on the current count only: a same-cycle pop
  // never opens a slot for a push while full.
  assign ext_ready  = ~fifo_full_s;
  assign push_s     = ext_valid & ~fifo_full_s;
  assign pop_req_s  = req_in & (addr_in == NBIOIN'(IOA_FIFO));
  assign pop_s      = pop_req_s & ~fifo_empty_s;
  assign stat_req_s = req_in & (addr_in == NBIOIN'(IOA_STAT));
  assign gpio_sel_s = addr_in - NBIOIN'(IOA_GPIO0);

  io_fifo #(
    .NBDATA (NUBITS),
    .DEPTH  (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (ext_data),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Post-update occupancy, used so itr tracks the count after this edge
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count_s + CW'(1);
      2'b01:   count_next_s = fifo_count_s - CW'(1);
      default: count_next_s = fifo_count_s;
    endcase
  end

  // Status word assembly; unused bits read as zero
  always_comb begin
    status_s               = '0;
    status_s[ST_EMPTY]     = fifo_empty_s;
    status_s[ST_FULL]      = fifo_full_s;
    status_s[ST_UNDF]      = underflow_r;
    status_s[ST_CNT +: CW] = fifo_count_s;
  end

  // Read-data source select by address
  always_comb begin
    rd_data_s = '0;
    if (addr_in == NBIOIN'(IOA_FIFO)) begin
      if (fifo_empty_s) begin
        rd_data_s = '0;
      end else begin
        rd_data_s = fifo_dout_s;
      end
    end else if (addr_in == NBIOIN'(IOA_STAT)) begin
      rd_data_s = status_s;
    end else begin
      rd_data_s = gpio_r[gpio_sel_s*NUBITS +: NUBITS];
    end
  end

  // Output port registers with one-cycle write strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q   <= '0;
      port_stb <= '0;
    end else begin
      port_stb <= '0;
      if (out_en) begin
        port_q[addr_out*NUBITS +: NUBITS] <= io_out;
        port_stb[addr_out]                <= 1'b1;
      end
    end
  end

  // GPIO sample stage, refreshed every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_r <= '0;
    end else begin
      gpio_r <= ext_gpio;
    end
  end

  // Read data register, sticky underflow flag and interrupt level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_in       <= '0;
      underflow_r <= 1'b0;
      itr         <= 1'b0;
    end else begin
      if (req_in) begin
        io_in <= rd_data_s;
      end
      if (pop_req_s && fifo_empty_s) begin
        underflow_r <= 1'b1;
      end else if (stat_req_s) begin
        underflow_r <= 1'b0;
      end
      itr <= (count_next_s >= CW'(ITRTHR));
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_io_port_bank;

  localparam int NUBITS = 16;
  localparam int NBIOIN = 2;
  localparam int NBIOOU = 2;
  localparam int FDEPTH = 8;
  localparam int ITRTHR = 4;

  logic        clk;
  logic        rst;
  logic [15:0] io_out;
  logic [1:0]  addr_out;
  logic        out_en;
  logic [1:0]  addr_in;
  logic        req_in;
  logic [15:0] io_in;
  logic        itr;
  logic [15:0] ext_data;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] ext_gpio;
  logic [63:0] port_q;
  logic [3:0]  port_stb;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] q[$];
  bit          undf_m;
  logic [15:0] port_m [4];
  logic [3:0]  stb_m;
  logic [15:0] io_m;
  bit          itr_m;
  logic [15:0] gpio_m [2];

  io_port_bank #(
    .NUBITS (NUBITS),
    .NBIOIN (NBIOIN),
    .NBIOOU (NBIOOU),
    .FDEPTH (FDEPTH),
    .ITRTHR (ITRTHR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io_out    (io_out),
    .addr_out  (addr_out),
    .out_en    (out_en),
    .addr_in   (addr_in),
    .req_in    (req_in),
    .io_in     (io_in),
    .itr       (itr),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .ext_gpio  (ext_gpio),
    .port_q    (port_q),
    .port_stb  (port_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ports_m();
    return {port_m[3], port_m[2], port_m[1], port_m[0]};
  endfunction

  task automatic model_reset();
    q.delete();
    undf_m = 1'b0;
    for (int i = 0; i < 4; i++) port_m[i] = 16'h0000;
    stb_m  = 4'b0000;
    io_m   = 16'h0000;
    itr_m  = 1'b0;
    gpio_m[0] = 16'h0000;
    gpio_m[1] = 16'h0000;
  endtask

  // one clock edge: predict from the driven inputs, then compare
  task automatic step();
    bit acc;
    int a;
    int st;
    acc   = ext_valid && (q.size() < FDEPTH);
    stb_m = 4'b0000;
    if (req_in) begin
      a = int'(addr_in);
      if (a == 0) begin
        if (q.size() == 0) begin
          io_m   = 16'h0000;
          undf_m = 1'b1;
        end else begin
          io_m = q.pop_front();
        end
      end else if (a == 1) begin
        st = 0;
        if (q.size() == 0) st = st + 1;
        if (q.size() == FDEPTH) st = st + 2;
        if (undf_m) st = st + 4;
        st = st + (q.size() * 8);
        io_m   = 16'(st);
        undf_m = 1'b0;
      end else begin
        io_m = gpio_m[a-2];
      end
    end
    if (acc) q.push_back(ext_data);
    if (out_en) begin
      port_m[addr_out] = io_out;
      stb_m = 4'(1 << addr_out);
    end
    itr_m = (q.size() >= ITRTHR);
    gpio_m[0] = ext_gpio[15:0];
    gpio_m[1] = ext_gpio[31:16];
    @(posedge clk);
    #1;
    chk("io_in", io_in, io_m);
    chk("itr", itr, itr_m);
    chk("ext_ready", ext_ready, (q.size() < FDEPTH));
    chk("port_q", port_q, ports_m());
    chk("port_stb", port_stb, stb_m);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    out_en = 1'b1; addr_out = a; io_out = d;
    step();
    out_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    req_in = 1'b1; addr_in = a;
    step();
    req_in = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    ext_valid = 1'b1; ext_data = d;
    step();
    ext_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; io_out = 16'h0000; addr_out = 2'd0; out_en = 1'b0;
    addr_in = 2'd0; req_in = 1'b0; ext_data = 16'h0000; ext_valid = 1'b0;
    ext_gpio = 32'h0000_0000;
    model_reset();
    #12;
    chk("rst_io_in", io_in, 16'h0000);
    chk("rst_itr", itr, 1'b0);
    chk("rst_ready", ext_ready, 1'b1);
    chk("rst_port_q", port_q, 64'h0);
    chk("rst_stb", port_stb, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    // port writes back to back
    wr(2'd2, 16'h1234);
    chk("stb_a2", port_stb, 4'b0100);
    chk("port2", port_q[47:32], 16'h1234);
    wr(2'd3, 16'hBEEF);
    chk("stb_a3", port_stb, 4'b1000);
    chk("port3", port_q[63:48], 16'hBEEF);
    step();
    chk("stb_idle", port_stb, 4'b0000);

    // fill to full
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
      if (i == 3) chk("itr_below_thr", itr, 1'b0);
      if (i == 4) chk("itr_at_thr", itr, 1'b1);
    end
    chk("ready_full", ext_ready, 1'b0);
    push(16'h0009);
    rd(2'd1);
    chk("stat_full", io_in, 16'h0042);

    // drain and underflow
    for (int i = 1; i <= 8; i++) begin
      rd(2'd0);
      chk("drain_data", io_in, 16'(i));
      if (i == 4) chk("itr_hold", itr, 1'b1);
      if (i == 5) chk("itr_fall", itr, 1'b0);
    end
    rd(2'd0);
    chk("undf_data", io_in, 16'h0000);
    rd(2'd1);
    chk("stat_undf", io_in, 16'h0005);
    rd(2'd1);
    chk("stat_clr", io_in, 16'h0001);

    // push and pop together on empty
    req_in = 1'b1; addr_in = 2'd0; ext_valid = 1'b1; ext_data = 16'h5A5A;
    step();
    req_in = 1'b0; ext_valid = 1'b0;
    chk("simul_pop", io_in, 16'h0000);
    rd(2'd1);
    chk("simul_stat", io_in, 16'h000C);
    rd(2'd0);
    chk("simul_next", io_in, 16'h5A5A);

    // gpio
    ext_gpio = {16'h00A5, 16'h0000};
    step();
    step();
    rd(2'd3);
    chk("gpio3", io_in, 16'h00A5);
    rd(2'd2);
    chk("gpio2", io_in, 16'h0000);

    // reset mid-operation
    wr(2'd1, 16'h0007);
    for (int i = 0; i < 4; i++) push(16'(16'h0100 + i));
    rd(2'd1);
    chk("pre_rst_itr", itr, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_itr", itr, 1'b0);
    chk("mid_rst_io_in", io_in, 16'h0000);
    chk("mid_rst_port_q", port_q, 64'h0);
    chk("mid_rst_ready", ext_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    rd(2'd0);
    chk("post_rst_pop", io_in, 16'h0000);
    rd(2'd1);
    chk("post_rst_stat", io_in, 16'h0005);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      req_in    = 1'($urandom_range(0, 1));
      addr_in   = 2'($urandom_range(0, 3));
      out_en    = 1'($urandom_range(0, 1));
      addr_out  = 2'($urandom_range(0, 3));
      io_out    = 16'($urandom);
      ext_valid = ($urandom_range(0, 99) < 55);
      ext_data  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ext_gpio = $urandom;
      step();
    end
    req_in = 1'b0; out_en = 1'b0; ext_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
